queue_reader: RTL and testbench

Drain-side companion of the nibble queue: pops 4-bit entries from an upstream queue's read port and assembles NIBBLES consecutive entries into one word. The word is presented downstream on a valid/ready interface. Sits between the queue and any wide consumer, such as a register-file loader or a debug sink. It is the only agent driving the queue's pop.

---
 rtl/liang_pkg.sv | 8 +
 rtl/queue_reader.sv | 87 ++++++++
 tb/tb_queue_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/liang_pkg.sv
// Shared types and constants for the nibble-queue drain side.
package liang_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic {FILL, HOLD} reader_state_e;

endpackage

// File: rtl/queue_reader.sv
// Pops nibbles from an upstream queue, packs NIBBLES of them into one word
// and presents that word on a valid/ready interface.
module queue_reader
   import liang_pkg::*;
#(
   parameter  int unsigned NIBBLES   = 8,
   parameter  bit          LSB_FIRST = 1'b1,
   localparam int unsigned WORD_W    = NIBBLE_W * NIBBLES
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                q_empty_i,
   input  logic [NIBBLE_W-1:0] q_data_i,
   output logic                q_pop_o,
   input  logic                flush_i,
   output logic                word_valid_o,
   input  logic                word_ready_i,
   output logic [WORD_W-1:0]   word_data_o,
   output logic [15:0]         word_cnt_o
);

   localparam int unsigned NIB_IDX_W = $clog2(NIBBLES);

   reader_state_e        state_q, state_d;
   logic [NIB_IDX_W-1:0] nib_q, nib_d;
   logic [WORD_W-1:0]    asm_q, asm_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 pop, accept, last;
   int unsigned          slot;

   always_comb begin
      state_d = state_q;
      nib_d   = nib_q;
      asm_d   = asm_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      accept  = (state_q == HOLD) & word_ready_i;
      pop     = rst_ni & ~flush_i & ~q_empty_i & ((state_q == FILL) | accept);
      last    = (nib_q == NIB_IDX_W'(NIBBLES - 1));
      slot    = LSB_FIRST ? int'(nib_q) : (NIBBLES - 1 - int'(nib_q));

      if (flush_i) begin
         state_d = FILL;
         nib_d   = '0;
      end else begin
         if (accept) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = FILL;
         end
         // A completing pop overrides the accept's return to FILL, so a
         // streaming consumer sees back-to-back words with no bubble.
         if (pop) begin
            asm_d[slot*NIBBLE_W +: NIBBLE_W] = q_data_i;
            if (last) begin
               nib_d   = '0;
               word_d  = asm_d;
               state_d = HOLD;
            end else begin
               nib_d = nib_q + NIB_IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FILL;
         nib_q   <= '0;
         asm_q   <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         asm_q   <= asm_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q_pop_o      = pop;
   assign word_valid_o = (state_q == HOLD);
   assign word_data_o  = word_q;
   assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: both orientations share one behavioural queue and
// are checked every cycle against a word-level model of the reader.
module tb_queue_reader;
   import liang_pkg::*;

   localparam int unsigned N = 8;
   localparam int unsigned W = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          ready = 1'b0;
   logic          q_empty = 1'b1;
   logic [3:0]    q_data = 4'h0;
   logic [3:0]    fifo[$];

   logic          pop_a, pop_b, valid_a, valid_b;
   logic [W-1:0]  data_a, data_b;
   logic [15:0]   cnt_a, cnt_b;

   int            total = 0;
   int            bad = 0;
   int            popped = 0;
   bit            do_pop = 1'b0;

   logic [3:0]    m_coll[$];
   bit            m_held = 1'b0;
   logic [W-1:0]  m_word_l = '0;
   logic [W-1:0]  m_word_m = '0;
   logic [15:0]   m_cnt = '0;
   bit            exp_pop;

   queue_reader #(.NIBBLES(N), .LSB_FIRST(1'b1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .q_empty_i(q_empty), .q_data_i(q_data),
      .q_pop_o(pop_a), .flush_i(flush), .word_valid_o(valid_a),
      .word_ready_i(ready), .word_data_o(data_a), .word_cnt_o(cnt_a));

   queue_reader #(.NIBBLES(N), .LSB_FIRST(1'b0)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .q_empty_i(q_empty), .q_data_i(q_data),
      .q_pop_o(pop_b), .flush_i(flush), .word_valid_o(valid_b),
      .word_ready_i(ready), .word_data_o(data_b), .word_cnt_o(cnt_b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      q_empty = (fifo.size() == 0);
      q_data  = q_empty ? 4'h0 : fifo[0];
   endtask

   task automatic push(input logic [3:0] v);
      fifo.push_back(v);
      refresh();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string name, input int max);
      int k = 0;
      while (!valid_a && k < max) begin
         step();
         k++;
      end
      chk({"timeout ", name}, 32'(valid_a), 32'd1);
   endtask

   // Model: a word is the N most recent popped nibbles since the last
   // completion/flush/reset; pop allowed whenever there is room to present it.
   always @(negedge clk) begin
      exp_pop = rst_n && !flush && !q_empty && (!m_held || ready);
      chk("pop_a", 32'(pop_a), 32'(exp_pop));
      chk("pop_b", 32'(pop_b), 32'(exp_pop));
      chk("valid_a", 32'(valid_a), 32'(rst_n && m_held));
      chk("valid_b", 32'(valid_b), 32'(rst_n && m_held));
      chk("cnt_a", 32'(cnt_a), rst_n ? 32'(m_cnt) : 32'd0);
      chk("cnt_b", 32'(cnt_b), rst_n ? 32'(m_cnt) : 32'd0);
      if (!rst_n) begin
         chk("rst_data_a", data_a, 32'd0);
         chk("rst_data_b", data_b, 32'd0);
      end else if (m_held) begin
         chk("data_a", data_a, m_word_l);
         chk("data_b", data_b, m_word_m);
      end
      do_pop = pop_a;
      if (pop_a) popped++;

      if (!rst_n) begin
         m_coll.delete();
         m_held   = 1'b0;
         m_word_l = '0;
         m_word_m = '0;
         m_cnt    = '0;
      end else if (flush) begin
         m_coll.delete();
         m_held = 1'b0;
      end else begin
         if (m_held && ready) begin
            m_cnt++;
            m_held = 1'b0;
         end
         if (exp_pop) begin
            m_coll.push_back(q_data);
            if (m_coll.size() == N) begin
               m_word_l = '0;
               m_word_m = '0;
               for (int i = 0; i < N; i++) begin
                  m_word_l |= W'(m_coll[i]) << (4 * i);
                  m_word_m |= W'(m_coll[i]) << (4 * (N - 1 - i));
               end
               m_held = 1'b1;
               m_coll.delete();
            end
         end
      end
   end

   // Upstream queue consumes its head just after the edge the DUT sampled it on.
   always @(posedge clk) begin
      #1;
      if (do_pop && fifo.size() > 0) begin
         void'(fifo.pop_front());
         refresh();
      end
   end

   initial begin
      #400000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int k;
      step();
      step();
      chk("reset_valid", 32'(valid_a), 32'd0);
      chk("reset_cnt", 32'(cnt_a), 32'd0);
      chk("reset_data", data_a, 32'd0);

      // Straight word, ready high
      rst_n = 1'b1;
      ready = 1'b1;
      popped = 0;
      for (int i = 1; i <= 8; i++) push(4'(i));
      wait_valid("w1", 20);
      chk("w1_lsb", data_a, 32'h87654321);
      chk("w1_msb", data_b, 32'h12345678);
      chk("w1_pops", 32'(popped), 32'd8);
      step();
      chk("w1_pulse", 32'(valid_a), 32'd0);
      chk("w1_cnt", 32'(cnt_a), 32'd1);

      // Back-pressure, then streaming
      ready = 1'b0;
      for (int i = 0; i < 16; i++) push(4'(i));
      repeat (20) step();
      chk("w2_held", 32'(valid_a), 32'd1);
      chk("w2_lsb", data_a, 32'h76543210);
      chk("w2_msb", data_b, 32'h01234567);
      chk("w2_nopop", 32'(pop_a), 32'd0);
      ready = 1'b1;
      step();
      k = 1;
      while (!valid_a && k < 20) begin
         step();
         k++;
      end
      chk("w3_latency", 32'(k), 32'd8);
      chk("w3_lsb", data_a, 32'hFEDCBA98);
      chk("w3_msb", data_b, 32'h89ABCDEF);
      step();
      chk("w3_cnt", 32'(cnt_a), 32'd3);

      // Starvation mid-word
      push(4'h5); push(4'h6); push(4'h7);
      repeat (12) step();
      chk("starve_valid", 32'(valid_a), 32'd0);
      chk("starve_pop", 32'(pop_a), 32'd0);
      chk("starve_nib", 32'(dut_a.nib_q), 32'd3);
      for (int i = 8; i <= 12; i++) push(4'(i));
      wait_valid("w4", 20);
      chk("w4_lsb", data_a, 32'hCBA98765);
      chk("w4_msb", data_b, 32'h56789ABC);
      step();
      chk("w4_cnt", 32'(cnt_a), 32'd4);

      // Flush a partial word
      for (int i = 1; i <= 5; i++) push(4'(i));
      repeat (8) step();
      chk("flush_nib_before", 32'(dut_a.nib_q), 32'd5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_nib_after", 32'(dut_a.nib_q), 32'd0);
      repeat (8) push(4'hA);
      wait_valid("w5", 20);
      chk("w5_lsb", data_a, 32'hAAAAAAAA);
      chk("w5_msb", data_b, 32'hAAAAAAAA);
      step();
      chk("w5_cnt", 32'(cnt_a), 32'd5);

      // Flush colliding with acceptance
      ready = 1'b0;
      repeat (8) push(4'h3);
      wait_valid("w6", 20);
      ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      ready = 1'b0;
      chk("fa_valid", 32'(valid_a), 32'd0);
      chk("fa_cnt", 32'(cnt_a), 32'd5);
      chk("fa_state", 32'(dut_a.state_q), 32'(FILL));

      // Reset while holding a word
      for (int i = 1; i <= 12; i++) push(4'(i));
      wait_valid("w7", 20);
      chk("w7_lsb", data_a, 32'h87654321);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_data", data_a, 32'd0);
      chk("rst_cnt", 32'(cnt_a), 32'd0);
      chk("rst_pop", 32'(pop_a), 32'd0);
      chk("rst_fifo", 32'(fifo.size()), 32'd4);
      step();
      rst_n = 1'b1;
      ready = 1'b1;
      push(4'hD); push(4'hE); push(4'hF); push(4'h0);
      wait_valid("w8", 20);
      chk("w8_lsb", data_a, 32'h0FEDCBA9);
      chk("w8_msb", data_b, 32'h9ABCDEF0);
      step();
      chk("w8_cnt", 32'(cnt_a), 32'd1);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
